gpu_mem_arbiter: RTL and testbench
==================================

# gpu_mem_arbiter

Parametrised N-master to single-DRAM memory arbiter that replaces the fixed three-master mux between the graphics pipeline masters (vertex fetch, shader core, framebuffer, texture unit, …) and the external DRAM port. It provides round-robin arbitration with an optional per-master locked-burst mode. It registers the DRAM command, tracks in-flight reads with a tag pipeline, and routes each read return to the master that issued it.

## Interface
Parameters:
- NUM_MASTERS, 3, number of requesting masters (≥1)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- RD_LATENCY, 2, fixed DRAM read latency in cycles (≥1)
- MAX_BURST, 4, max consecutive grants to one locked master (≥1)

Ports (clock domain, reset: one clock `clk`; reset `rst` is synchronous, active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req  in  NUM_MASTERS  per-master request
- i_we  in  NUM_MASTERS  per-master write enable (1 = write, 0 = read)
- i_lock  in  NUM_MASTERS  per-master burst-lock request
- i_addr  in  NUM_MASTERS×ADDR_WIDTH  packed per-master address
- i_wdata  in  NUM_MASTERS×DATA_WIDTH  packed per-master write data
- o_gnt  out  NUM_MASTERS  one-hot grant, combinational
- o_rvalid  out  NUM_MASTERS  one-hot read-return valid, registered
- o_rdata  out  DATA_WIDTH  shared read-return data, registered
- o_dram_req  out  1  DRAM command valid
- o_dram_we  out  1  DRAM write enable
- o_dram_addr  out  ADDR_WIDTH  DRAM address
- o_dram_wdata  out  DATA_WIDTH  DRAM write data
- i_dram_rdata  in  DATA_WIDTH  DRAM read data, valid RD_LATENCY cycles after a read command

## Operation
- Masters hold i_req, i_we, i_addr and i_wdata stable until o_gnt is seen. The request completes in the grant cycle, and the master may change its inputs on the next cycle.
- Arbitration:
  - At most one grant per cycle. The DRAM accepts one command every cycle, so there is no backpressure.
  - Winner is the first requester scanning from rr_ptr upward, modulo NUM_MASTERS.
  - After a normal grant, rr_ptr becomes (winner+1) mod NUM_MASTERS.
- Burst lock:
  - Applies when the winner has i_lock high. The block records it as owner and increments burst_cnt.
  - Next cycle, if the owner still requests with i_lock high and burst_cnt < MAX_BURST, the owner wins regardless of rr_ptr.
  - rr_ptr stays at (owner+1) for the whole burst.
  - The burst ends when the owner drops i_req or i_lock, or when burst_cnt reaches MAX_BURST. At that point burst_cnt clears and normal round-robin resumes from rr_ptr.
  - A lost cycle (owner not requesting) ends the burst.
- Command register:
  - The granted request is registered onto o_dram_* at the next edge.
  - o_dram_req = 1 for exactly one cycle per grant.
  - o_dram_addr, o_dram_we and o_dram_wdata hold their last values when o_dram_req = 0.
- Read tracking:
  - A tag pipeline of RD_LATENCY stages shifts {valid, master_id} every cycle.
  - A stage is loaded when o_dram_req & ~o_dram_we. Writes carry no tag.
- Read return:
  - When the tag pipeline output is valid, i_dram_rdata is captured into o_rdata at the next edge.
  - o_rvalid[id] is set for one cycle at that same edge.
  - o_rdata holds its value otherwise.
- Reads and writes from different masters interleave freely. A return and a new grant in the same cycle are independent.
- NUM_MASTERS = 1: rr_ptr width is max(1, $clog2(NUM_MASTERS)), and the single master is granted whenever it requests.

## Timing
- Reset values: o_gnt = 0 (no grant while rst = 1), o_rvalid = 0, o_rdata = 0, o_dram_req = 0, o_dram_we = 0, o_dram_addr = 0, o_dram_wdata = 0. Internally rr_ptr = 0, burst_cnt = 0, all tag stages invalid.
- Grant in cycle t. DRAM command at t+1. i_dram_rdata is sampled at t+1+RD_LATENCY. o_rvalid/o_rdata appear at t+2+RD_LATENCY.
- Sustained throughput is one command per cycle, and one return per cycle for back-to-back reads.
- Reset asserted mid-operation: all in-flight reads are discarded, and no o_rvalid is produced for commands issued before reset. The pending command register is cleared on the same edge.
- Simultaneous lock requests: only the winner becomes owner. Other lock requesters wait for round-robin order.

## Test plan
- Single read: master 1 reads addr 0x100 at cycle 5, with DRAM returning 0xDEADBEEF at cycle 6+RD_LATENCY -> o_gnt = 3'b010 at cycle 5; o_dram_req/addr 0x100/we 0 at cycle 6; o_rvalid = 3'b010 and o_rdata = 0xDEADBEEF at cycle 7+RD_LATENCY.
- Round-robin fairness: all 3 masters hold i_req for 6 cycles, no lock -> grant order 0,1,2,0,1,2, and each master is granted exactly 2 times.
- Burst lock: MAX_BURST = 4, master 2 holds i_lock+i_req, masters 0 and 1 also requesting -> master 2 granted 4 consecutive cycles, then master 0, then master 1.
- Interleaved returns: reads from masters 0, 2, 1 on consecutive cycles, with a write from master 0 in between -> o_rvalid returns 001, 100, 010 in issue order with matching data; the write produces no rvalid.
- Reset mid-flight: two reads issued, then rst pulsed 1 cycle before their return -> o_rvalid stays 0 and all outputs read 0 the cycle after reset; rr_ptr restarts at master 0.
- Parameter sweep: NUM_MASTERS ∈ {1, 5} and RD_LATENCY ∈ {1, 4} -> latency and grant order rules above hold.

Source files
------------

// File: rtl/gpu_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : gpu_mem_arbiter_if
// Brief    : Bus bundle between the graphics masters, the arbiter and the DRAM
//            command/return port. The arbiter uses the slave view. Whoever
//            drives the masters and models the DRAM uses the master view.
// Revision : 1.0 - initial release
// ============================================================================
interface gpu_mem_arbiter_if #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
);
    logic [NUM_MASTERS-1:0]            i_req;
    logic [NUM_MASTERS-1:0]            i_we;
    logic [NUM_MASTERS-1:0]            i_lock;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] i_addr;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] i_wdata;
    logic [NUM_MASTERS-1:0]            o_gnt;
    logic [NUM_MASTERS-1:0]            o_rvalid;
    logic [DATA_WIDTH-1:0]             o_rdata;
    logic                              o_dram_req;
    logic                              o_dram_we;
    logic [ADDR_WIDTH-1:0]             o_dram_addr;
    logic [DATA_WIDTH-1:0]             o_dram_wdata;
    logic [DATA_WIDTH-1:0]             i_dram_rdata;

    // Arbiter view
    modport slave (
        input  i_req, i_we, i_lock, i_addr, i_wdata, i_dram_rdata,
        output o_gnt, o_rvalid, o_rdata,
        output o_dram_req, o_dram_we, o_dram_addr, o_dram_wdata
    );

    // Master / DRAM-model view
    modport master (
        output i_req, i_we, i_lock, i_addr, i_wdata, i_dram_rdata,
        input  o_gnt, o_rvalid, o_rdata,
        input  o_dram_req, o_dram_we, o_dram_addr, o_dram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/gpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gpu_mem_arbiter
// Brief    : N-master to single-DRAM arbiter. It provides round-robin
//            arbitration with an optional locked burst per master, a
//            registered DRAM command, and a tag pipeline that routes each read
//            return to the master that issued it.
// Revision : 1.0 - initial release
// ============================================================================
module gpu_mem_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int RD_LATENCY  = 2,
    parameter int MAX_BURST   = 4
) (
    input  logic              clk,
    input  logic              rst,
    gpu_mem_arbiter_if.slave  bus
);
    localparam int c_ptr_w = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int c_cnt_w = $clog2(MAX_BURST + 1);
    localparam logic [c_ptr_w:0]   c_num_m     = (c_ptr_w + 1)'(NUM_MASTERS);
    localparam logic [c_cnt_w-1:0] c_max_burst = c_cnt_w'(MAX_BURST);

    // Arbitration state
    logic [c_ptr_w-1:0]     rr_ptr_q,    rr_ptr_d;
    logic [c_ptr_w-1:0]     owner_q,     owner_d;
    logic [c_cnt_w-1:0]     burst_cnt_q, burst_cnt_d;

    // DRAM command register
    logic                   dram_req_q,   dram_req_d;
    logic                   dram_we_q,    dram_we_d;
    logic [ADDR_WIDTH-1:0]  dram_addr_q,  dram_addr_d;
    logic [DATA_WIDTH-1:0]  dram_wdata_q, dram_wdata_d;
    logic [c_ptr_w-1:0]     cmd_id_q,     cmd_id_d;

    // Read tag pipeline and return registers
    logic [RD_LATENCY-1:0]  tag_vld_q, tag_vld_d;
    logic [c_ptr_w-1:0]     tag_id_q [RD_LATENCY];
    logic [c_ptr_w-1:0]     tag_id_d [RD_LATENCY];
    logic [NUM_MASTERS-1:0] rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]  rdata_q,  rdata_d;

    // Combinational arbitration results
    logic                   w_hold;
    logic                   w_found;
    logic [c_ptr_w-1:0]     w_win;
    logic [c_ptr_w:0]       w_scan;
    logic [c_ptr_w:0]       w_win_p1;
    logic [NUM_MASTERS-1:0] w_gnt;

    // Pick the winner: a live locked owner keeps the bus, otherwise scan from rr_ptr
    always_comb begin
        w_hold  = (burst_cnt_q != '0) && (burst_cnt_q < c_max_burst) &&
                  bus.i_req[owner_q] && bus.i_lock[owner_q];
        w_found = 1'b0;
        w_win   = '0;
        w_scan  = '0;
        if (w_hold) begin
            w_found = 1'b1;
            w_win   = owner_q;
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                w_scan = {1'b0, rr_ptr_q} + (c_ptr_w + 1)'(i);
                if (w_scan >= c_num_m) begin
                    w_scan = w_scan - c_num_m;
                end
                if (!w_found && bus.i_req[w_scan[c_ptr_w-1:0]]) begin
                    w_found = 1'b1;
                    w_win   = w_scan[c_ptr_w-1:0];
                end
            end
        end
        // No grant may leak out while reset is held
        w_gnt = '0;
        if (w_found && !rst) begin
            w_gnt[w_win] = 1'b1;
        end
    end

    // Advance the pointer and burst bookkeeping, and capture the granted command
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        burst_cnt_d  = '0;
        dram_req_d   = 1'b0;
        dram_we_d    = dram_we_q;
        dram_addr_d  = dram_addr_q;
        dram_wdata_d = dram_wdata_q;
        cmd_id_d     = cmd_id_q;
        w_win_p1     = {1'b0, w_win} + (c_ptr_w + 1)'(1);
        if (w_win_p1 == c_num_m) begin
            w_win_p1 = '0;
        end
        if (w_found) begin
            rr_ptr_d   = w_win_p1[c_ptr_w-1:0];
            dram_req_d = 1'b1;
            dram_we_d  = bus.i_we[w_win];
            cmd_id_d   = w_win;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (w_win == c_ptr_w'(i)) begin
                    dram_addr_d  = bus.i_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    dram_wdata_d = bus.i_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            // A locked winner either extends the current burst or opens a new one
            if (bus.i_lock[w_win]) begin
                owner_d     = w_win;
                burst_cnt_d = w_hold ? (burst_cnt_q + c_cnt_w'(1)) : c_cnt_w'(1);
            end
        end
    end

    // Shift read tags and turn the oldest valid tag into a routed return
    always_comb begin
        tag_vld_d[0] = dram_req_q & ~dram_we_q;
        tag_id_d[0]  = cmd_id_q;
        for (int s = 1; s < RD_LATENCY; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
        end
        rvalid_d = '0;
        rdata_d  = rdata_q;
        if (tag_vld_q[RD_LATENCY-1]) begin
            rvalid_d[tag_id_q[RD_LATENCY-1]] = 1'b1;
            rdata_d                          = bus.i_dram_rdata;
        end
    end

    // State registers. Reset discards in-flight reads and the pending command.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            burst_cnt_q  <= '0;
            dram_req_q   <= 1'b0;
            dram_we_q    <= 1'b0;
            dram_addr_q  <= '0;
            dram_wdata_q <= '0;
            cmd_id_q     <= '0;
            tag_vld_q    <= '0;
            for (int s = 0; s < RD_LATENCY; s++) begin
                tag_id_q[s] <= '0;
            end
            rvalid_q     <= '0;
            rdata_q      <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            burst_cnt_q  <= burst_cnt_d;
            dram_req_q   <= dram_req_d;
            dram_we_q    <= dram_we_d;
            dram_addr_q  <= dram_addr_d;
            dram_wdata_q <= dram_wdata_d;
            cmd_id_q     <= cmd_id_d;
            tag_vld_q    <= tag_vld_d;
            for (int s = 0; s < RD_LATENCY; s++) begin
                tag_id_q[s] <= tag_id_d[s];
            end
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
        end
    end

    assign bus.o_gnt        = w_gnt;
    assign bus.o_rvalid     = rvalid_q;
    assign bus.o_rdata      = rdata_q;
    assign bus.o_dram_req   = dram_req_q;
    assign bus.o_dram_we    = dram_we_q;
    assign bus.o_dram_addr  = dram_addr_q;
    assign bus.o_dram_wdata = dram_wdata_q;
endmodule
`default_nettype wire

// File: tb/tb_gpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpu_mem_arbiter
// Brief    : Self-checking bench for gpu_mem_arbiter. It uses three instances:
//            (3 masters, latency 2, burst 4), (5, 4, 2) and (1, 1, 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpu_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct packed {
        int          c;
        int          id;
        logic [31:0] d;
    } ret_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    logic [4:0]      req_v   [3];
    logic [4:0]      we_v    [3];
    logic [4:0]      lock_v  [3];
    logic [5*AW-1:0] addr_v  [3];
    logic [5*DW-1:0] wdata_v [3];
    logic [4:0]      gnt_v   [3];
    logic [4:0]      rv_v    [3];
    logic [DW-1:0]   rdata_v [3];
    logic            dreq_v  [3];
    logic            dwe_v   [3];
    logic [AW-1:0]   daddr_v [3];
    logic [DW-1:0]   dwdata_v[3];
    logic            ovr_en;
    logic [DW-1:0]   ovr_val;
    logic [DW-1:0]   dram_rdata;

    // DRAM read data is a fixed function of the cycle number, so expected returns can be computed.
    function automatic logic [31:0] dram_data(input int c);
        return 32'(c) * 32'h9E37_79B1 + 32'h0BAD_F00D;
    endfunction

    assign dram_rdata = ovr_en ? ovr_val : dram_data(cyc);

    gpu_mem_arbiter_if #(.NUM_MASTERS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    gpu_mem_arbiter_if #(.NUM_MASTERS(5), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
    gpu_mem_arbiter_if #(.NUM_MASTERS(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

    gpu_mem_arbiter #(.NUM_MASTERS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .MAX_BURST(4))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    gpu_mem_arbiter #(.NUM_MASTERS(5), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(4), .MAX_BURST(2))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    gpu_mem_arbiter #(.NUM_MASTERS(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .MAX_BURST(1))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    assign bus0.i_req  = req_v[0][2:0];
    assign bus0.i_we   = we_v[0][2:0];
    assign bus0.i_lock = lock_v[0][2:0];
    assign bus0.i_addr = addr_v[0][3*AW-1:0];
    assign bus0.i_wdata = wdata_v[0][3*DW-1:0];
    assign bus0.i_dram_rdata = dram_rdata;
    assign gnt_v[0] = {2'b00, bus0.o_gnt};
    assign rv_v[0]  = {2'b00, bus0.o_rvalid};
    assign rdata_v[0] = bus0.o_rdata;
    assign dreq_v[0] = bus0.o_dram_req;
    assign dwe_v[0]  = bus0.o_dram_we;
    assign daddr_v[0] = bus0.o_dram_addr;
    assign dwdata_v[0] = bus0.o_dram_wdata;

    assign bus1.i_req  = req_v[1];
    assign bus1.i_we   = we_v[1];
    assign bus1.i_lock = lock_v[1];
    assign bus1.i_addr = addr_v[1];
    assign bus1.i_wdata = wdata_v[1];
    assign bus1.i_dram_rdata = dram_rdata;
    assign gnt_v[1] = bus1.o_gnt;
    assign rv_v[1]  = bus1.o_rvalid;
    assign rdata_v[1] = bus1.o_rdata;
    assign dreq_v[1] = bus1.o_dram_req;
    assign dwe_v[1]  = bus1.o_dram_we;
    assign daddr_v[1] = bus1.o_dram_addr;
    assign dwdata_v[1] = bus1.o_dram_wdata;

    assign bus2.i_req  = req_v[2][0:0];
    assign bus2.i_we   = we_v[2][0:0];
    assign bus2.i_lock = lock_v[2][0:0];
    assign bus2.i_addr = addr_v[2][AW-1:0];
    assign bus2.i_wdata = wdata_v[2][DW-1:0];
    assign bus2.i_dram_rdata = dram_rdata;
    assign gnt_v[2] = {4'b0000, bus2.o_gnt};
    assign rv_v[2]  = {4'b0000, bus2.o_rvalid};
    assign rdata_v[2] = bus2.o_rdata;
    assign dreq_v[2] = bus2.o_dram_req;
    assign dwe_v[2]  = bus2.o_dram_we;
    assign daddr_v[2] = bus2.o_dram_addr;
    assign dwdata_v[2] = bus2.o_dram_wdata;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 3; i++) begin
            req_v[i] = '0; we_v[i] = '0; lock_v[i] = '0; addr_v[i] = '0; wdata_v[i] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        req_v[0] = 5'b00111; req_v[1] = 5'b11111; req_v[2] = 5'b00001;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (gnt_v[i] !== 5'b0) begin
                bad++; $display("FAIL reset_gnt inst%0d: got %b expected 0", i, gnt_v[i]);
            end
            total++;
            if ({rv_v[i], rdata_v[i], dreq_v[i], dwe_v[i], daddr_v[i], dwdata_v[i]} !== '0) begin
                bad++;
                $display("FAIL reset_regs inst%0d: got rv=%b rdata=%h req=%b we=%b addr=%h wdata=%h expected all 0",
                         i, rv_v[i], rdata_v[i], dreq_v[i], dwe_v[i], daddr_v[i], dwdata_v[i]);
            end
        end
        tick();
        clear_inputs();
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        tick();
        req_v[0] = 5'b00010;
        addr_v[0][1*AW +: AW] = 32'h100;
        @(negedge clk);
        total++;
        if (gnt_v[0] !== 5'b00010) begin bad++; $display("FAIL single_gnt: got %b expected 00010", gnt_v[0]); end
        tick();
        req_v[0] = '0;
        @(negedge clk);
        total++;
        if ({dreq_v[0], dwe_v[0], daddr_v[0]} !== {1'b1, 1'b0, 32'h100}) begin
            bad++; $display("FAIL single_cmd: got req=%b we=%b addr=%h expected 1 0 00000100", dreq_v[0], dwe_v[0], daddr_v[0]);
        end
        tick();
        @(negedge clk);
        total++;
        if ({dreq_v[0], daddr_v[0], rv_v[0]} !== {1'b0, 32'h100, 5'b0}) begin
            bad++; $display("FAIL single_hold: got req=%b addr=%h rv=%b expected 0 00000100 0", dreq_v[0], daddr_v[0], rv_v[0]);
        end
        tick();
        ovr_en = 1'b1; ovr_val = 32'hDEAD_BEEF;
        tick();
        ovr_en = 1'b0;
        @(negedge clk);
        total++;
        if ({rv_v[0], rdata_v[0]} !== {5'b00010, 32'hDEAD_BEEF}) begin
            bad++; $display("FAIL single_ret: got rv=%b rdata=%h expected 00010 deadbeef", rv_v[0], rdata_v[0]);
        end
        tick();
        @(negedge clk);
        total++;
        if ({rv_v[0], rdata_v[0]} !== {5'b00000, 32'hDEAD_BEEF}) begin
            bad++; $display("FAIL single_rhold: got rv=%b rdata=%h expected 0 deadbeef", rv_v[0], rdata_v[0]);
        end
    endtask

    task automatic test_round_robin();
        int cnt [3];
        do_reset();
        cnt = '{0, 0, 0};
        req_v[0] = 5'b00111;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total++;
            if (gnt_v[0] !== (5'b1 << (k % 3))) begin
                bad++; $display("FAIL rr_order k%0d: got %b expected %b", k, gnt_v[0], 5'b1 << (k % 3));
            end
            for (int m = 0; m < 3; m++) if (gnt_v[0][m]) cnt[m]++;
            tick();
        end
        for (int m = 0; m < 3; m++) begin
            total++;
            if (cnt[m] != 2) begin bad++; $display("FAIL rr_count m%0d: got %0d expected 2", m, cnt[m]); end
        end
        clear_inputs();
    endtask

    task automatic test_burst_lock();
        logic [4:0] exp_seq [7];
        exp_seq = '{5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00001, 5'b00010, 5'b00100};
        do_reset();
        req_v[0] = 5'b00010;
        tick();
        req_v[0] = 5'b00111; lock_v[0] = 5'b00100;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            total++;
            if (gnt_v[0] !== exp_seq[k]) begin
                bad++; $display("FAIL burst_seq k%0d: got %b expected %b", k, gnt_v[0], exp_seq[k]);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        int          op_m [4];
        logic        op_w [4];
        int          t0;
        logic [4:0]  exp_rv;
        logic [31:0] exp_d;
        op_m = '{0, 0, 2, 1};
        op_w = '{1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        t0 = cyc;
        exp_d = '0;
        for (int k = 0; k < 9; k++) begin
            req_v[0] = '0; we_v[0] = '0;
            if (k < 4) begin
                req_v[0][op_m[k]] = 1'b1;
                we_v[0][op_m[k]]  = op_w[k];
                addr_v[0][op_m[k]*AW +: AW] = 32'h200 + 32'(k);
            end
            @(negedge clk);
            if (k < 4) begin
                total++;
                if (gnt_v[0] !== (5'b1 << op_m[k])) begin
                    bad++; $display("FAIL b2b_gnt k%0d: got %b expected %b", k, gnt_v[0], 5'b1 << op_m[k]);
                end
            end
            exp_rv = '0;
            if (k == 4) begin exp_rv = 5'b00001; exp_d = dram_data(t0 + 3); end
            if (k == 6) begin exp_rv = 5'b00100; exp_d = dram_data(t0 + 5); end
            if (k == 7) begin exp_rv = 5'b00010; exp_d = dram_data(t0 + 6); end
            total++;
            if ({rv_v[0], rdata_v[0]} !== {exp_rv, exp_d}) begin
                bad++; $display("FAIL b2b_ret k%0d: got rv=%b rdata=%h expected rv=%b rdata=%h", k, rv_v[0], rdata_v[0], exp_rv, exp_d);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req_v[0] = 5'b00001;
        tick();
        req_v[0] = 5'b00010;
        tick();
        req_v[0] = 5'b00100; we_v[0] = 5'b00100;
        addr_v[0][2*AW +: AW] = 32'h300; wdata_v[0][2*DW +: DW] = 32'hA5A5_A5A5;
        tick();
        we_v[0] = '0; req_v[0] = 5'b00111; rst = 1'b1;
        @(negedge clk);
        total++;
        if (gnt_v[0] !== 5'b0) begin bad++; $display("FAIL mid_gnt_in_rst: got %b expected 0", gnt_v[0]); end
        tick();
        rst = 1'b0; req_v[0] = '0;
        @(negedge clk);
        total++;
        if ({rv_v[0], rdata_v[0], dreq_v[0], dwe_v[0], daddr_v[0], dwdata_v[0]} !== '0) begin
            bad++;
            $display("FAIL mid_clear: got rv=%b rdata=%h req=%b we=%b addr=%h wdata=%h expected all 0",
                     rv_v[0], rdata_v[0], dreq_v[0], dwe_v[0], daddr_v[0], dwdata_v[0]);
        end
        tick();
        req_v[0] = 5'b00111;
        @(negedge clk);
        total++;
        if ({gnt_v[0], rv_v[0]} !== {5'b00001, 5'b0}) begin
            bad++; $display("FAIL mid_restart: got gnt=%b rv=%b expected gnt=00001 rv=0", gnt_v[0], rv_v[0]);
        end
        tick();
        req_v[0] = '0;
        @(negedge clk);
        total++;
        if (rv_v[0] !== 5'b0) begin bad++; $display("FAIL mid_norv: got %b expected 0", rv_v[0]); end
        tick();
        clear_inputs();
    endtask

    task automatic test_random(input int inst, input int ncyc);
        int          n, lat, mb, rr, owner, cnt, win;
        bit          hold;
        bit          pend [5];
        logic [4:0]  exp_gnt, exp_rv;
        logic        exp_dreq, exp_dwe;
        logic [31:0] exp_daddr, exp_dwdata, exp_rdata;
        ret_t        q [$];
        ret_t        r;
        n   = (inst == 0) ? 3 : (inst == 1) ? 5 : 1;
        lat = (inst == 0) ? 2 : (inst == 1) ? 4 : 1;
        mb  = (inst == 0) ? 4 : (inst == 1) ? 2 : 1;
        do_reset();
        rr = 0; owner = 0; cnt = 0;
        exp_dreq = 0; exp_dwe = 0; exp_daddr = '0; exp_dwdata = '0; exp_rdata = '0;
        for (int i = 0; i < 5; i++) pend[i] = 0;
        for (int c = 0; c < ncyc; c++) begin
            for (int m = 0; m < n; m++) begin
                if (!pend[m] && $urandom_range(0, 99) < 60) begin
                    pend[m] = 1;
                    we_v[inst][m] = ($urandom_range(0, 2) == 0);
                    addr_v[inst][m*AW +: AW]  = $urandom;
                    wdata_v[inst][m*DW +: DW] = $urandom;
                end
                req_v[inst][m]  = pend[m];
                lock_v[inst][m] = ($urandom_range(0, 99) < 70);
            end
            @(negedge clk);
            // Expected winner from the arbitration rules
            win = -1; hold = 0;
            if (cnt > 0 && cnt < mb && req_v[inst][owner] && lock_v[inst][owner]) begin
                win = owner; hold = 1;
            end else begin
                for (int k = 0; k < n; k++) begin
                    if (win < 0 && req_v[inst][(rr + k) % n]) win = (rr + k) % n;
                end
            end
            exp_gnt = (win >= 0) ? (5'b1 << win) : 5'b0;
            total++;
            if (gnt_v[inst] !== exp_gnt) begin
                bad++; $display("FAIL rand_gnt inst%0d cyc%0d: got %b expected %b", inst, cyc, gnt_v[inst], exp_gnt);
            end
            total++;
            if ({dreq_v[inst], dwe_v[inst], daddr_v[inst], dwdata_v[inst]} !== {exp_dreq, exp_dwe, exp_daddr, exp_dwdata}) begin
                bad++;
                $display("FAIL rand_cmd inst%0d cyc%0d: got req=%b we=%b addr=%h wdata=%h expected req=%b we=%b addr=%h wdata=%h",
                         inst, cyc, dreq_v[inst], dwe_v[inst], daddr_v[inst], dwdata_v[inst], exp_dreq, exp_dwe, exp_daddr, exp_dwdata);
            end
            exp_rv = '0;
            if (q.size() > 0 && q[0].c == cyc) begin
                r = q.pop_front();
                exp_rv[r.id] = 1'b1;
                exp_rdata = r.d;
            end
            total++;
            if ({rv_v[inst], rdata_v[inst]} !== {exp_rv, exp_rdata}) begin
                bad++;
                $display("FAIL rand_ret inst%0d cyc%0d: got rv=%b rdata=%h expected rv=%b rdata=%h",
                         inst, cyc, rv_v[inst], rdata_v[inst], exp_rv, exp_rdata);
            end
            // Model update for the coming edge
            if (win >= 0) begin
                exp_dreq   = 1'b1;
                exp_dwe    = we_v[inst][win];
                exp_daddr  = addr_v[inst][win*AW +: AW];
                exp_dwdata = wdata_v[inst][win*DW +: DW];
                if (!exp_dwe) begin
                    r.c = cyc + 2 + lat; r.id = win; r.d = dram_data(cyc + 1 + lat);
                    q.push_back(r);
                end
                if (lock_v[inst][win]) begin
                    cnt = hold ? cnt + 1 : 1;
                    owner = win;
                end else begin
                    cnt = 0;
                end
                rr = (win + 1) % n;
                pend[win] = 0;
            end else begin
                exp_dreq = 1'b0;
                cnt = 0;
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        ovr_en = 1'b0;
        ovr_val = '0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_burst_lock();
        test_back_to_back();
        test_reset_midflight();
        test_random(0, 400);
        test_random(1, 400);
        test_random(2, 200);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
